// File: rtl/uart_tx_stream.sv
// uart_tx_stream: buffered UART transmitter.
// A word-wide valid/ready port fills a power-of-two FIFO. A serializer drains it
// into frames of start, DATA_BITS data bits (LSB first), an optional parity bit
// and STOP_BITS stop bits. Frames run back-to-back while the FIFO holds data.
module uart_tx_stream #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_pin,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    // The baud counter also times the whole stop period, which may be two bits long.
    localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [AW:0]   FULL      = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   LVL_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state;
    logic [CW-1:0]         baud_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_BITS-1:0]  shreg;
    logic                  par_bit;

    logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [DATA_BITS-1:0]  head;
    logic                  push;
    logic                  pop;

    assign tx_ready = (fifo_level != FULL);
    assign push     = tx_valid & tx_ready;
    assign head     = mem[rd_ptr];
    // The serializer takes a word when idle, or on the final stop cycle so the
    // next start bit follows with no idle gap.
    assign pop      = (fifo_level != '0) &&
                      ((state == S_IDLE) || ((state == S_STOP) && (baud_cnt == STOP_LAST)));
    assign busy     = (state != S_IDLE) | (fifo_level != '0);

    // FIFO storage: no reset needed, validity is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= tx_data;
    end

    // FIFO pointers, level and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_ONE;
                2'b01:   fifo_level <= fifo_level - LVL_ONE;
                default: fifo_level <= fifo_level;
            endcase
            if (tx_valid && !tx_ready)
                overflow <= 1'b1;
        end
    end

    // Frame sequencer: start, data, optional parity, stop, then idle or next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    if (pop) begin
                        shreg   <= head;
                        par_bit <= (PARITY == 1) ? ~^head : ^head;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        shreg    <= shreg >> 1;
                        if (bit_cnt == DATA_LAST)
                            state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        else
                            bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end
                S_PARITY: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (baud_cnt == STOP_LAST) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shreg   <= head;
                            par_bit <= (PARITY == 1) ? ~^head : ^head;
                            state   <= S_START;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Registered line driver: follows the sequencer one cycle later, so every
    // bit keeps its full length and the pin never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_pin <= 1'b1;
        end else begin
            case (state)
                S_START:  tx_pin <= 1'b0;
                S_DATA:   tx_pin <= shreg[0];
                S_PARITY: tx_pin <= par_bit;
                default:  tx_pin <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// tb_uart_tx_stream: three transmitter configurations with a shared clock and
// reset. Writes push the expected word per channel; per-channel monitors decode
// the serial line at mid-bit and compare the frame against a frame model.
module tb_uart_tx_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    longint cyc = 0;

    logic [2:0] v = '0;
    logic [8:0] dat [3];
    logic       rdy0, rdy1, rdy2, pin0, pin1, pin2, bsy0, bsy1, bsy2, ovf0, ovf1, ovf2;
    logic [4:0] lvl0;
    logic [2:0] lvl1;
    logic [1:0] lvl2;
    logic [2:0] rdy, pin, bsy, ovf;

    assign rdy = {rdy2, rdy1, rdy0};
    assign pin = {pin2, pin1, pin0};
    assign bsy = {bsy2, bsy1, bsy0};
    assign ovf = {ovf2, ovf1, ovf0};

    int npass = 0;
    int nchk  = 0;

    logic [8:0] expq   [3][$];
    longint     starts [3][$];
    logic [2:0] ovf_exp = '0;
    int         dbk [3] = '{8, 7, 9};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_stream u0 (
        .clk(clk), .rst(rst), .tx_data(dat[0][7:0]), .tx_valid(v[0]), .tx_ready(rdy0),
        .tx_pin(pin0), .busy(bsy0), .fifo_level(lvl0), .overflow(ovf0)
    );

    uart_tx_stream #(.CLKS_PER_BIT(6), .DATA_BITS(7), .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(2)) u1 (
        .clk(clk), .rst(rst), .tx_data(dat[1][6:0]), .tx_valid(v[1]), .tx_ready(rdy1),
        .tx_pin(pin1), .busy(bsy1), .fifo_level(lvl1), .overflow(ovf1)
    );

    uart_tx_stream #(.CLKS_PER_BIT(4), .DATA_BITS(9), .FIFO_DEPTH(2), .PARITY(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst), .tx_data(dat[2]), .tx_valid(v[2]), .tx_ready(rdy2),
        .tx_pin(pin2), .busy(bsy2), .fifo_level(lvl2), .overflow(ovf2)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        nchk++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Line image of one frame, bit 0 first on the wire: 0, data LSB first, parity, stop ones.
    function automatic logic [15:0] frame_of(input logic [8:0] w, input int db, input int par);
        logic [15:0] f;
        int ones;
        f = '1;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < db; i++) begin
            f[1+i] = w[i];
            ones += int'(w[i]);
        end
        if (par == 1) f[1+db] = (ones % 2 == 0);
        if (par == 2) f[1+db] = (ones % 2 == 1);
        return f;
    endfunction

    // Decodes frames on channel k; a reset inside a frame abandons it.
    task automatic mon(input int k, input int cpb, input int db, input int par, input int sb);
        int n;
        logic [15:0] got, exp, msk;
        logic [8:0] w;
        bit ab;
        longint s;
        n = 1 + db + ((par != 0) ? 1 : 0) + sb;
        msk = 16'((32'd1 << n) - 1);
        forever begin
            @(negedge clk);
            if (rst || pin[k]) continue;
            s = cyc;
            got = '1;
            ab = 1'b0;
            for (int o = 0; o <= (n - 1) * cpb + cpb / 2; o++) begin
                if (o > 0) @(negedge clk);
                if (rst) begin
                    ab = 1'b1;
                    break;
                end
                if (o % cpb == cpb / 2) got[o / cpb] = pin[k];
            end
            if (ab) continue;
            starts[k].push_back(s);
            if (expq[k].size() == 0) begin
                chk($sformatf("unexpected_frame_ch%0d", k), 64'(got & msk), -1);
            end else begin
                w = expq[k].pop_front();
                exp = frame_of(w, db, par);
                chk($sformatf("frame_ch%0d_word%0h", k, w), 64'(got & msk), 64'(exp & msk));
            end
        end
    endtask

    // One write attempt on channel k spanning one clock edge; caller sits at a negedge.
    task automatic wr(input int k, input logic [8:0] w);
        v[k] = 1'b1;
        dat[k] = w;
        if (rdy[k]) expq[k].push_back(w & 9'((1 << dbk[k]) - 1));
        else ovf_exp[k] = 1'b1;
        @(negedge clk);
        v[k] = 1'b0;
    endtask

    task automatic drain(input int bound, input string nm);
        int i;
        for (i = 0; i < bound; i++) begin
            if (expq[0].size() == 0 && expq[1].size() == 0 && expq[2].size() == 0 && bsy == 3'b000)
                break;
            @(negedge clk);
        end
        chk(nm, (i < bound) ? 1 : 0, 1);
    endtask

    initial begin
        int acc;
        int i;
        longint n0;
        for (int k = 0; k < 3; k++) dat[k] = '0;
        fork
            mon(0, 87, 8, 0, 1);
            mon(1, 6, 7, 2, 2);
            mon(2, 4, 9, 1, 1);
        join_none

        repeat (3) @(negedge clk);
        chk("rst_ready", rdy, 3'b111);
        chk("rst_pin", pin, 3'b111);
        chk("rst_busy", bsy, 3'b000);
        chk("rst_ovf", ovf, 3'b000);
        chk("rst_levels", {lvl0, lvl1, lvl2}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single 0x55 frame: latency and busy duration.
        wr(0, 9'h055);
        n0 = cyc;
        chk("lat_pin_edgeN", pin0, 1);
        @(negedge clk);
        chk("lat_pin_edgeN1", pin0, 1);
        chk("pop_level", lvl0, 0);
        @(negedge clk);
        chk("lat_pin_edgeN2", pin0, 0);
        repeat (int'(n0 + 870 - cyc)) @(negedge clk);
        chk("busy_last_cycle", bsy0, 1);
        @(negedge clk);
        chk("busy_dropped", bsy0, 0);
        drain(2000, "drain_t1");

        // Back-to-back frames: one popped right away, two queued.
        starts[0].delete();
        wr(0, 9'h0A5);
        wr(0, 9'h03C);
        wr(0, 9'h0FF);
        chk("b2b_level", lvl0, 2);
        drain(4000, "drain_t2");
        chk("b2b_frames", starts[0].size(), 3);
        if (starts[0].size() == 3) begin
            chk("b2b_gap1", starts[0][1] - starts[0][0], 870);
            chk("b2b_gap2", starts[0][2] - starts[0][1], 870);
        end
        chk("b2b_level_end", lvl0, 0);

        // Fill to full while the line is slow, then one rejected write.
        acc = 0;
        for (i = 0; i < 40 && rdy0; i++) begin
            wr(0, 9'(i + 1));
            acc++;
        end
        chk("full_accepted", acc, 17);
        chk("full_level", lvl0, 16);
        chk("full_ready", rdy0, 0);
        chk("ovf_before", ovf0, 0);
        wr(0, 9'h0EE);
        chk("ovf_after", ovf0, 1);
        chk("full_level_hold", lvl0, 16);

        // Parity corner words on the 7E2 and 9O1 channels.
        wr(1, 9'h041);
        wr(2, 9'h000);
        wr(2, 9'h001);
        repeat (60) @(negedge clk);
        wr(2, 9'h1FF);
        wr(2, 9'h100);
        repeat (60) @(negedge clk);

        // Random traffic on the fast channels, overflow allowed.
        for (int c = 0; c < 600; c++) begin
            for (int k = 1; k < 3; k++) begin
                v[k] = ($urandom_range(0, 2) == 0);
                dat[k] = 9'($urandom);
                if (v[k]) begin
                    if (rdy[k]) expq[k].push_back(dat[k] & 9'((1 << dbk[k]) - 1));
                    else ovf_exp[k] = 1'b1;
                end
            end
            @(negedge clk);
        end
        v = '0;
        chk("rand_ovf1", ovf1, ovf_exp[1]);
        chk("rand_ovf2", ovf2, ovf_exp[2]);
        drain(30000, "drain_rand");

        // Reset during data bit 3 of a frame with another word queued.
        wr(0, 9'h05A);
        wr(0, 9'h033);
        for (i = 0; i < 200 && pin0; i++) @(negedge clk);
        chk("t6_start_seen", pin0, 0);
        repeat (4 * 87 + 43) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_pin_async", pin0, 1);
        chk("t6_level", lvl0, 0);
        chk("t6_ovf", ovf0, 0);
        chk("t6_busy", bsy0, 0);
        chk("t6_ready", rdy0, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        expq[0].delete();
        starts[0].delete();
        ovf_exp = '0;
        @(negedge clk);
        wr(0, 9'h0C3);
        drain(2000, "drain_t6");
        chk("t6_frames", starts[0].size(), 1);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
